// File: rtl/boot_loader.sv
// Framed program loader: takes length, payload and checksum over valid/ready,
// writes the payload into memory from 0x00 and releases the core on a good checksum.
module boot_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       reload,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       cpu_run,
  output logic       load_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t     state_r;
  logic [8:0] cnt_r;
  logic [7:0] addr_r;
  logic [7:0] sum_r;
  logic       ready_s;
  logic       accept_s;

  // 8-bit modular checksum step; carry out is discarded
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // Ready is a pure decode of state so the upstream sees it in the same cycle
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      S_IDLE, S_LOAD, S_CHECK: ready_s = 1'b1;
      default:                 ready_s = 1'b0;
    endcase
  end

  assign in_ready = rst_n & ready_s;
  assign accept_s = in_valid & in_ready;

  // Frame FSM with registered memory-port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= 9'd0;
      addr_r    <= 8'h00;
      sum_r     <= 8'h00;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      cpu_run   <= 1'b0;
      load_err  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            // A length byte of zero encodes a full 256-byte image
            cnt_r   <= (in_data == 8'h00) ? 9'h100 : {1'b0, in_data};
            addr_r  <= 8'h00;
            sum_r   <= 8'h00;
            busy    <= 1'b1;
            state_r <= S_LOAD;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (accept_s) begin
            mem_addr  <= addr_r;
            mem_wdata <= in_data;
            mem_we    <= 1'b1;
            addr_r    <= addr_r + 8'h01;
            cnt_r     <= cnt_r - 9'd1;
            sum_r     <= csum_add(sum_r, in_data);
            if (cnt_r == 9'd1) begin
              state_r <= S_CHECK;
            end else begin
              state_r <= S_LOAD;
            end
          end else begin
            state_r <= S_LOAD;
          end
        end
        S_CHECK: begin
          if (accept_s) begin
            busy <= 1'b0;
            if (in_data == sum_r) begin
              cpu_run <= 1'b1;
              state_r <= S_RUN;
            end else begin
              load_err <= 1'b1;
              state_r  <= S_ERROR;
            end
          end else begin
            state_r <= S_CHECK;
          end
        end
        S_RUN, S_ERROR: begin
          if (reload) begin
            cpu_run  <= 1'b0;
            load_err <= 1'b0;
            state_r  <= S_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          cpu_run  <= 1'b0;
          load_err <= 1'b0;
          busy     <= 1'b0;
          state_r  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: good/bad frames, 256-byte frame, gaps, reset and reload.
module tb_boot_loader;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       reload;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       cpu_run;
  logic       load_err;
  logic       busy;

  int errors_r = 0;
  int checks_r = 0;

  boot_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_run   (cpu_run),
    .load_err  (load_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte with valid high, let it transfer, then sample just after the edge
  task automatic xfer(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    check_val({tag, "_we"}, {15'd0, mem_we}, 16'd1);
    check_val({tag, "_addr"}, {8'd0, mem_addr}, {8'd0, a});
    check_val({tag, "_data"}, {8'd0, mem_wdata}, {8'd0, d});
  endtask

  task automatic do_reload();
    @(negedge clk);
    in_valid = 1'b0;
    reload   = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  logic       gap_vld [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] gap_dat [7] = '{8'h02, 8'hAA, 8'hAA, 8'h5A, 8'hAA, 8'h0F, 8'h69};
  logic       gap_we  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       gap_busy[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] gap_addr[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    #3;
    check_val("rst_ready", {15'd0, in_ready}, 16'd0);
    check_val("rst_outs", {mem_addr, mem_wdata}, 16'h0000);
    check_val("rst_flags", {12'd0, mem_we, cpu_run, load_err, busy}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("idle_ready", {15'd0, in_ready}, 16'd1);

    // Good 3-byte frame
    xfer(8'h03);
    check_val("g_busy", {15'd0, busy}, 16'd1);
    check_val("g_nowe_len", {15'd0, mem_we}, 16'd0);
    xfer(8'hA1); check_write("g0", 8'h00, 8'hA1);
    xfer(8'hB2); check_write("g1", 8'h01, 8'hB2);
    xfer(8'hC3); check_write("g2", 8'h02, 8'hC3);
    xfer(8'h16);
    check_val("g_run", {15'd0, cpu_run}, 16'd1);
    check_val("g_err", {15'd0, load_err}, 16'd0);
    check_val("g_we_off", {15'd0, mem_we}, 16'd0);
    check_val("g_busy_off", {15'd0, busy}, 16'd0);
    check_val("g_ready_off", {15'd0, in_ready}, 16'd0);
    idle_cycle();
    check_val("g_run_hold", {15'd0, cpu_run}, 16'd1);

    // Reload from RUN, then a second frame
    do_reload();
    check_val("rl_run", {15'd0, cpu_run}, 16'd0);
    check_val("rl_ready", {15'd0, in_ready}, 16'd1);
    xfer(8'h01);
    xfer(8'h7E); check_write("rl0", 8'h00, 8'h7E);
    xfer(8'h7E);
    check_val("rl_run2", {15'd0, cpu_run}, 16'd1);

    // Bad checksum
    do_reload();
    xfer(8'h03);
    xfer(8'hA1); check_write("b0", 8'h00, 8'hA1);
    xfer(8'hB2); check_write("b1", 8'h01, 8'hB2);
    xfer(8'hC3); check_write("b2", 8'h02, 8'hC3);
    xfer(8'h17);
    check_val("b_err", {15'd0, load_err}, 16'd1);
    check_val("b_run", {15'd0, cpu_run}, 16'd0);
    check_val("b_ready", {15'd0, in_ready}, 16'd0);
    xfer(8'h55);
    check_val("b_nowe", {15'd0, mem_we}, 16'd0);
    check_val("b_err_hold", {15'd0, load_err}, 16'd1);
    check_val("b_busy", {15'd0, busy}, 16'd0);
    do_reload();
    check_val("be_err_clr", {15'd0, load_err}, 16'd0);
    check_val("be_ready", {15'd0, in_ready}, 16'd1);

    // Full 256-byte frame: sum of 0..255 mod 256 is 0x80
    xfer(8'h00);
    for (int i = 0; i < 256; i++) begin
      xfer(8'(i));
      check_write("f", 8'(i), 8'(i));
    end
    xfer(8'h80);
    check_val("f_nowe_wrap", {15'd0, mem_we}, 16'd0);
    check_val("f_run", {15'd0, cpu_run}, 16'd1);
    check_val("f_err", {15'd0, load_err}, 16'd0);

    // Handshake gaps
    do_reload();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = gap_vld[i];
      in_data  = gap_dat[i];
      @(posedge clk);
      #1;
      check_val($sformatf("gap_we%0d", i), {15'd0, mem_we}, {15'd0, gap_we[i]});
      check_val($sformatf("gap_busy%0d", i), {15'd0, busy}, {15'd0, gap_busy[i]});
      if (gap_we[i]) begin
        check_val($sformatf("gap_addr%0d", i), {8'd0, mem_addr}, {8'd0, gap_addr[i]});
      end
    end
    check_val("gap_wdata", {8'd0, mem_wdata}, 16'h000F);
    check_val("gap_run", {15'd0, cpu_run}, 16'd1);

    // Reset in the middle of a 4-byte payload
    do_reload();
    xfer(8'h04);
    xfer(8'h11);
    xfer(8'h22);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("mr_ready", {15'd0, in_ready}, 16'd0);
    check_val("mr_outs", {mem_addr, mem_wdata}, 16'h0000);
    check_val("mr_flags", {12'd0, mem_we, cpu_run, load_err, busy}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(8'h01);
    xfer(8'h33); check_write("mr0", 8'h00, 8'h33);
    xfer(8'h33);
    check_val("mr_run", {15'd0, cpu_run}, 16'd1);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
    $finish;
  end

endmodule
